// File: rtl/audio_cmd_queue_if.sv
// APB3 slave bus bundle for the audio command queue.
interface audio_cmd_queue_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/audio_cmd_queue.sv
// APB3 command FIFO feeding a bit-serial two-wire sound module driver,
// including the module power-up reset sequence.
module audio_cmd_queue #(
    parameter int CMD_BITS     = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int RST_DELAY    = 100000,
    parameter int RST_LOW      = 600000,
    parameter int BOOT_CYCLES  = 30000000,
    parameter int START_CYCLES = 200000,
    parameter int BIT_CYCLES   = 60000,
    parameter int GAP_CYCLES   = 20000
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    audio_cmd_queue_if.slave   apb,
    input  logic               snd_busy,
    output logic               snd_clk,
    output logic               snd_data,
    output logic               snd_rst_n
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;

    localparam logic [31:0] T_RST_ON  = 32'(RST_DELAY);
    localparam logic [31:0] T_RST_OFF = 32'(RST_DELAY + RST_LOW);
    localparam logic [31:0] T_BOOTED  = 32'(RST_DELAY + RST_LOW + BOOT_CYCLES);
    localparam logic [31:0] T_START   = 32'(START_CYCLES - 1);
    localparam logic [31:0] T_DATA    = 32'(BIT_CYCLES / 3);
    localparam logic [31:0] T_RISE    = 32'((2 * BIT_CYCLES) / 3);
    localparam logic [31:0] T_BITEND  = 32'(BIT_CYCLES - 1);
    localparam logic [31:0] T_GAP     = 32'(GAP_CYCLES - 1);
    localparam logic [AW:0] DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(CMD_BITS - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_START, S_BIT, S_GAP} state_t;

    state_t              state, state_n;
    logic [31:0]         cnt, cnt_n;
    logic [IW-1:0]       idx, idx_n;
    logic                clk_n, data_n, rstn_n, done_n;
    logic                init_done, msb_q, pop;
    logic                msb_first, wait_busy, busy_q, overflow;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         level;
    logic [CMD_BITS-1:0] mem [FIFO_DEPTH];
    logic [CMD_BITS-1:0] cmd_q;
    logic [31:0]         prdata;

    logic [1:0] sel;
    logic       wr_stb, reinit, clr_ovf, push_req, push, full, empty, cur_bit;
    logic       unused_apb;

    assign sel      = apb.PADDR[3:2];
    assign wr_stb   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign reinit   = wr_stb && (sel == 2'd1) && apb.PWDATA[2];
    assign clr_ovf  = wr_stb && (sel == 2'd1) && apb.PWDATA[3];
    assign push_req = wr_stb && (sel == 2'd0) && !reinit;
    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign cur_bit  = msb_q ? cmd_q[LAST_IDX - idx] : cmd_q[idx];
    assign unused_apb = ^{apb.PADDR, apb.PWDATA};

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            msb_first <= 1'b0;
            wait_busy <= 1'b0;
            busy_q    <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            busy_q <= snd_busy;
            if (wr_stb && (sel == 2'd1)) begin
                msb_first <= apb.PWDATA[0];
                wait_busy <= apb.PWDATA[1];
            end
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clr_ovf)             overflow <= 1'b0;
            if (reinit) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level <= level + 1'b1;
                else if (!push && pop) level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= apb.PWDATA[CMD_BITS-1:0];
        if (pop)  cmd_q <= mem[rd_ptr];
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state     <= S_INIT;
            cnt       <= '0;
            idx       <= '0;
            snd_clk   <= 1'b1;
            snd_data  <= 1'b1;
            snd_rst_n <= 1'b1;
            init_done <= 1'b0;
            msb_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            snd_clk   <= clk_n;
            snd_data  <= data_n;
            snd_rst_n <= rstn_n;
            init_done <= done_n;
            if (pop) msb_q <= msb_first;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        idx_n   = idx;
        clk_n   = snd_clk;
        data_n  = snd_data;
        rstn_n  = snd_rst_n;
        done_n  = init_done;
        pop     = 1'b0;
        if (reinit) begin
            state_n = S_INIT;
            cnt_n   = '0;
            idx_n   = '0;
            clk_n   = 1'b1;
            data_n  = 1'b1;
            rstn_n  = 1'b1;
            done_n  = 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    clk_n  = 1'b1;
                    data_n = 1'b1;
                    if (cnt == T_RST_ON)  rstn_n = 1'b0;
                    if (cnt == T_RST_OFF) rstn_n = 1'b1;
                    if (cnt == T_BOOTED) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end
                S_IDLE: begin
                    clk_n  = 1'b1;
                    data_n = 1'b1;
                    cnt_n  = '0;
                    if (!empty && (!wait_busy || !busy_q)) begin
                        pop     = 1'b1;
                        clk_n   = 1'b0;
                        state_n = S_START;
                    end
                end
                S_START: begin
                    clk_n  = 1'b0;
                    data_n = 1'b1;
                    if (cnt == T_START) begin
                        state_n = S_BIT;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end
                end
                S_BIT: begin
                    if (cnt == '0)     clk_n  = 1'b0;
                    if (cnt == T_DATA) data_n = cur_bit;
                    if (cnt == T_RISE) clk_n  = 1'b1;
                    if (cnt == T_BITEND) begin
                        cnt_n = '0;
                        if (idx == LAST_IDX) state_n = S_GAP;
                        else                 idx_n   = idx + 1'b1;
                    end
                end
                S_GAP: begin
                    // Data returns high one cycle into the gap, clear of the last rising edge.
                    clk_n  = 1'b1;
                    data_n = 1'b1;
                    if (cnt == T_GAP) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = S_INIT;
            endcase
        end
    end

    always_comb begin
        prdata = '0;
        case (sel)
            2'd1: prdata[1:0] = {wait_busy, msb_first};
            2'd2: begin
                prdata[0]    = init_done;
                prdata[1]    = (state != S_IDLE);
                prdata[2]    = full;
                prdata[3]    = empty;
                prdata[4]    = overflow;
                prdata[15:8] = 8'(level);
            end
            default: prdata = '0;
        endcase
    end

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
endmodule

// File: tb/tb_audio_cmd_queue.sv
// Directed bench for audio_cmd_queue with shortened timing parameters.
module tb_audio_cmd_queue;
    logic PCLK = 1'b0;
    logic PRESERN = 1'b0;
    logic snd_busy = 1'b0;
    logic snd_clk, snd_data, snd_rst_n;

    int n_assert = 0;
    int n_fail   = 0;
    int cap_base = 0;
    bit cap_q[$];

    audio_cmd_queue_if apb();

    audio_cmd_queue #(
        .CMD_BITS(16), .FIFO_DEPTH(4), .RST_DELAY(10), .RST_LOW(20),
        .BOOT_CYCLES(30), .START_CYCLES(8), .BIT_CYCLES(6), .GAP_CYCLES(5)
    ) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .apb(apb), .snd_busy(snd_busy),
        .snd_clk(snd_clk), .snd_data(snd_data), .snd_rst_n(snd_rst_n)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge snd_clk) if (PRESERN) cap_q.push_back(snd_data);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = a; apb.PWDATA = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        #1 d = apb.PRDATA;
        @(posedge PCLK); #1;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    // Edge 0 is the first clock edge spent in INIT.
    task automatic check_init();
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = 32'h8;
        for (int i = 0; i < 66; i++) begin
            @(posedge PCLK); #1;
            check("init_rst_n", {31'd0, snd_rst_n}, (i >= 10 && i < 30) ? 32'd0 : 32'd1);
            check("init_clk", {31'd0, snd_clk}, 32'd1);
            check("init_data", {31'd0, snd_data}, 32'd1);
            check("init_done", {31'd0, apb.PRDATA[0]}, (i >= 60) ? 32'd1 : 32'd0);
        end
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        bit done = 1'b0;
        n = 0;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = 32'h8;
        while (!done && n < bound) begin
            @(posedge PCLK); #1;
            n++;
            if (apb.PRDATA[1] == 1'b0 && apb.PRDATA[3] == 1'b1) done = 1'b1;
        end
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        check("idle_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_bits(input int nbits, input int bound);
        int n = 0;
        while ((cap_q.size() - cap_base) < nbits && n < bound) begin
            @(posedge PCLK); #1;
            n++;
        end
        check("bits_seen", {31'd0, ((cap_q.size() - cap_base) >= nbits)}, 32'd1);
    endtask

    function automatic logic [15:0] cap_word(input int k);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++)
            if (cap_base + k * 16 + i < cap_q.size()) w[i] = cap_q[cap_base + k * 16 + i];
        return w;
    endfunction

    initial begin
        logic [31:0] rd;
        int ncyc, nsave, guard;
        bit exp_lsb [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        bit exp_msb [16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};
        logic [15:0] ovf_cmds [4] = '{16'h1234, 16'h00FF, 16'hF00F, 16'h8001};

        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;

        // Reset state
        #12;
        check("rst_clk", {31'd0, snd_clk}, 32'd1);
        check("rst_data", {31'd0, snd_data}, 32'd1);
        check("rst_rst_n", {31'd0, snd_rst_n}, 32'd1);
        check("pready", {31'd0, apb.PREADY}, 32'd1);
        check("pslverr", {31'd0, apb.PSLVERR}, 32'd0);
        apb.PSEL = 1'b1; apb.PADDR = 32'h8; #1;
        check("rst_status", apb.PRDATA, 32'h0000_000A);
        apb.PADDR = 32'h4; #1;
        check("rst_ctrl", apb.PRDATA, 32'h0);
        apb.PADDR = 32'hC; #1;
        check("rsvd_read", apb.PRDATA, 32'h0);
        apb.PSEL = 1'b0;

        @(negedge PCLK); PRESERN = 1'b1;
        check_init();

        // LSB-first transmit with latency and duration
        cap_base = cap_q.size();
        apb_write(32'h0, 32'h0000_A5C3);
        check("lat_n1_clk", {31'd0, snd_clk}, 32'd1);
        @(posedge PCLK); #1;
        check("lat_n2_clk", {31'd0, snd_clk}, 32'd0);
        wait_idle(400, ncyc);
        check("cmd_duration", ncyc, 32'd109);
        check("lsb_count", cap_q.size() - cap_base, 32'd16);
        for (int i = 0; i < 16; i++)
            check("lsb_bit", {31'd0, cap_q[cap_base + i]}, {31'd0, exp_lsb[i]});

        // MSB-first transmit
        apb_write(32'h4, 32'h1);
        apb_read(32'h4, rd);
        check("ctrl_msb", rd, 32'h1);
        cap_base = cap_q.size();
        apb_write(32'h0, 32'h0000_A5C3);
        wait_idle(400, ncyc);
        check("msb_count", cap_q.size() - cap_base, 32'd16);
        for (int i = 0; i < 16; i++)
            check("msb_bit", {31'd0, cap_q[cap_base + i]}, {31'd0, exp_msb[i]});

        // Overflow: five pushes while INIT holds the queue
        apb_write(32'h4, 32'h4);
        cap_base = cap_q.size();
        for (int k = 0; k < 4; k++) apb_write(32'h0, {16'd0, ovf_cmds[k]});
        apb_write(32'h0, 32'h0000_DEAD);
        apb_read(32'h8, rd);
        check("ovf_status", rd, 32'h0000_0416);
        apb_write(32'h4, 32'h8);
        apb_read(32'h8, rd);
        check("clr_ovf_status", rd, 32'h0000_0406);
        apb_read(32'h4, rd);
        check("ctrl_pulses_read0", rd, 32'h0);
        wait_idle(1000, ncyc);
        check("ovf_count", cap_q.size() - cap_base, 32'd64);
        for (int k = 0; k < 4; k++)
            check("ovf_word", {16'd0, cap_word(k)}, {16'd0, ovf_cmds[k]});

        // wait_busy holds the queue while the module reports busy
        snd_busy = 1'b1;
        apb_write(32'h4, 32'h2);
        apb_write(32'h0, 32'h0000_0F0F);
        cap_base = cap_q.size();
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK); #1;
            check("busy_hold_clk", {31'd0, snd_clk}, 32'd1);
        end
        apb_read(32'h8, rd);
        check("busy_status", rd, 32'h0000_0101);
        snd_busy = 1'b0;
        @(posedge PCLK); #1;
        check("busy_n1_clk", {31'd0, snd_clk}, 32'd1);
        @(posedge PCLK); #1;
        check("busy_n2_clk", {31'd0, snd_clk}, 32'd0);
        wait_idle(400, ncyc);
        check("busy_word", {16'd0, cap_word(0)}, 32'h0000_0F0F);

        // reinit during BIT with two commands still queued
        apb_write(32'h4, 32'h0);
        cap_base = cap_q.size();
        apb_write(32'h0, 32'h0000_1111);
        apb_write(32'h0, 32'h0000_2222);
        apb_write(32'h0, 32'h0000_3333);
        wait_bits(3, 400);
        apb_write(32'h4, 32'h4);
        check("reinit_clk", {31'd0, snd_clk}, 32'd1);
        check("reinit_data", {31'd0, snd_data}, 32'd1);
        nsave = cap_q.size();
        check_init();
        apb_read(32'h8, rd);
        check("reinit_status", rd, 32'h0000_0009);
        repeat (30) @(posedge PCLK);
        #1;
        check("reinit_no_bits", cap_q.size(), nsave);

        // Asynchronous reset mid-transfer
        cap_base = cap_q.size();
        apb_write(32'h0, 32'h0000_5555);
        wait_bits(2, 400);
        guard = 0;
        while (snd_clk !== 1'b0 && guard < 50) begin
            @(posedge PCLK); #1;
            guard++;
        end
        check("areset_clk_low", {31'd0, snd_clk}, 32'd0);
        #2 PRESERN = 1'b0;
        #1;
        check("areset_clk", {31'd0, snd_clk}, 32'd1);
        check("areset_data", {31'd0, snd_data}, 32'd1);
        check("areset_rst_n", {31'd0, snd_rst_n}, 32'd1);
        apb.PSEL = 1'b1; apb.PADDR = 32'h8; #1;
        check("areset_status", apb.PRDATA, 32'h0000_000A);
        apb.PSEL = 1'b0;
        @(negedge PCLK); PRESERN = 1'b1;
        check_init();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
